enum_cnt_seq: RTL and testbench

- Measurement sequencer for the threshold-crossing period counter (restart input, valid output, count bus).
- On each start request it re-arms the counter 2^LOG2_AVG times and captures each completed period count.
- It averages the captured counts and presents one result word.
- A per-sample watchdog aborts the measurement when the input signal never produces a complete period.
- Sits between the filter control registers and the counter instance.

---
 rtl/enum_cnt_seq.sv | 140 ++++++++++++++
 tb/tb_enum_cnt_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enum_cnt_seq.sv
// Measurement sequencer for the threshold-crossing period counter.
// It re-arms the counter 2^LOG2_AVG times, captures each completed
// period count on a rising edge of cnt_valid, and presents the truncated
// average. A per-sample watchdog stops the measurement if no period ever
// completes, and abort cancels a measurement at any point.
module enum_cnt_seq #(
    parameter int W_N_MAX  = 16,
    parameter int LOG2_AVG = 2,
    parameter int TIMEOUT  = 65535,
    parameter int W_TO     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                cnt_valid,
    input  logic [W_N_MAX-1:0]  cnt_count,
    output logic                cnt_rst,
    output logic                cnt_enable,
    output logic                busy,
    output logic [LOG2_AVG:0]   sample_idx,
    output logic [W_N_MAX-1:0]  result,
    output logic                result_valid,
    output logic                timeout_err
);

    // Accumulator holds the sum of 2^LOG2_AVG full-scale counts without wrapping.
    localparam int                 W_ACC     = W_N_MAX + LOG2_AVG;
    localparam logic [LOG2_AVG:0]  N_SAMPLES = (LOG2_AVG + 1)'(1 << LOG2_AVG);
    localparam logic [W_TO-1:0]    TO_LAST   = W_TO'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_VALID,
        CAPTURE,
        DONE
    } state_t;

    state_t              state;
    logic [W_ACC-1:0]    acc;
    logic [W_N_MAX-1:0]  latched;
    logic [W_TO-1:0]     watchdog;
    logic                cnt_valid_q;
    logic                valid_rise;
    logic [LOG2_AVG:0]   sample_idx_next;

    // A sample is only a fresh low-to-high transition; a level held high
    // across a re-arm must not be counted twice.
    assign valid_rise      = cnt_valid & ~cnt_valid_q;
    assign sample_idx_next = sample_idx + 1'b1;

    // Sequencer FSM with registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            latched      <= '0;
            watchdog     <= '0;
            cnt_valid_q  <= 1'b0;
            cnt_rst      <= 1'b0;
            cnt_enable   <= 1'b0;
            busy         <= 1'b0;
            sample_idx   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            // NOTE: every register here uses <=, so each branch below reads
            // the pre-edge values of acc, sample_idx and watchdog.
            cnt_valid_q  <= cnt_valid;
            // NOTE: the two pulse outputs default low each cycle and are only
            // raised for the single cycle that needs them.
            cnt_rst      <= 1'b0;
            result_valid <= 1'b0;

            if (abort && state != IDLE) begin
                // Abort discards the measurement; result and error flag hold.
                state      <= IDLE;
                busy       <= 1'b0;
                cnt_enable <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= ARM;
                            acc         <= '0;
                            sample_idx  <= '0;
                            timeout_err <= 1'b0;
                            cnt_rst     <= 1'b1;
                            busy        <= 1'b1;
                            cnt_enable  <= 1'b0;
                        end
                    end
                    ARM: begin
                        watchdog   <= '0;
                        cnt_enable <= 1'b1;
                        state      <= WAIT_VALID;
                    end
                    WAIT_VALID: begin
                        watchdog <= watchdog + 1'b1;
                        if (valid_rise) begin
                            // An edge on the last watchdog cycle still counts.
                            latched    <= cnt_count;
                            cnt_enable <= 1'b0;
                            state      <= CAPTURE;
                        end else if (watchdog == TO_LAST) begin
                            timeout_err <= 1'b1;
                            cnt_enable  <= 1'b0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    CAPTURE: begin
                        acc        <= acc + W_ACC'(latched);
                        sample_idx <= sample_idx_next;
                        if (sample_idx_next == N_SAMPLES) begin
                            state <= DONE;
                        end else begin
                            cnt_rst <= 1'b1;
                            state   <= ARM;
                        end
                    end
                    DONE: begin
                        result       <= W_N_MAX'(acc >> LOG2_AVG);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                    default: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cnt_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enum_cnt_seq.sv
// Self-checking bench for enum_cnt_seq. Stimulus is generated per
// measurement; expected outputs come from the documented latency rules
// (start -> ARM -> WAIT -> edge -> CAPTURE -> ... -> result pulse) and
// from plain arithmetic on the chosen sample counts.
module tb_enum_cnt_seq;

    localparam int W_N_MAX   = 16;
    localparam int LOG2_AVG  = 2;
    localparam int TIMEOUT   = 100;
    localparam int W_TO      = 16;
    localparam int N_SAMPLES = 1 << LOG2_AVG;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic                cnt_valid;
    logic [W_N_MAX-1:0]  cnt_count;
    logic                cnt_rst;
    logic                cnt_enable;
    logic                busy;
    logic [LOG2_AVG:0]   sample_idx;
    logic [W_N_MAX-1:0]  result;
    logic                result_valid;
    logic                timeout_err;

    enum_cnt_seq #(
        .W_N_MAX  (W_N_MAX),
        .LOG2_AVG (LOG2_AVG),
        .TIMEOUT  (TIMEOUT),
        .W_TO     (W_TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .cnt_valid    (cnt_valid),
        .cnt_count    (cnt_count),
        .cnt_rst      (cnt_rst),
        .cnt_enable   (cnt_enable),
        .busy         (busy),
        .sample_idx   (sample_idx),
        .result       (result),
        .result_valid (result_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int rst_pulses   = 0;
    int rv_pulses    = 0;
    logic [W_N_MAX-1:0] exp_result = '0;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (cnt_rst === 1'b1) rst_pulses++;
        if (result_valid === 1'b1) rv_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock; outputs are looked at 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W_N_MAX-1:0] rand_cnt();
        return ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    endfunction

    function automatic logic rand_start(input bit noisy);
        return noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic do_start(input bit with_abort);
        start = 1'b1;
        abort = with_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("arm_rst", cnt_rst, 1);
        check("arm_busy", busy, 1);
        check("arm_en", cnt_enable, 0);
        check("arm_idx", sample_idx, 0);
        check("arm_err", timeout_err, 0);
    endtask

    // Entered during an ARM cycle; leaves in the next ARM cycle or, for the
    // last sample, one cycle after the result pulse.
    task automatic run_sample(input logic [W_N_MAX-1:0] cnt, input int gap, input int hold,
                              input bit last, input int idx, input bit noisy,
                              input logic [W_N_MAX-1:0] want);
        cnt_valid = 1'b0;
        start     = rand_start(noisy);
        step();
        check("wait_en", cnt_enable, 1);
        check("wait_rst", cnt_rst, 0);
        for (int g = 0; g < gap; g++) begin
            start     = rand_start(noisy);
            cnt_count = 16'($urandom);
            step();
            check("wait_en_gap", cnt_enable, 1);
        end
        cnt_valid = 1'b1;
        cnt_count = cnt;
        start     = rand_start(noisy);
        step();
        check("cap_en", cnt_enable, 0);
        check("cap_busy", busy, 1);
        check("cap_idx", sample_idx, idx);
        cnt_valid = (hold > 1);
        cnt_count = 16'($urandom);
        start     = rand_start(noisy);
        step();
        check("post_idx", sample_idx, idx + 1);
        check("post_busy", busy, 1);
        check("post_rst", cnt_rst, last ? 0 : 1);
        cnt_valid = 1'b0;
        start     = 1'b0;
        if (last) begin
            step();
            check("done_rv", result_valid, 1);
            check("done_res", result, want);
            check("done_busy", busy, 0);
            step();
            check("done_rv_clr", result_valid, 0);
            check("done_res_hold", result, want);
        end
    endtask

    task automatic run_samples(input logic [W_N_MAX-1:0] cnts [N_SAMPLES], input int from, input bit noisy);
        longint sum = 0;
        logic [W_N_MAX-1:0] want;
        for (int i = 0; i < N_SAMPLES; i++) sum += longint'(cnts[i]);
        want = W_N_MAX'(sum >> LOG2_AVG);
        for (int i = from; i < N_SAMPLES; i++)
            run_sample(cnts[i], $urandom_range(0, 5), $urandom_range(1, 2),
                       i == N_SAMPLES - 1, i, noisy, want);
        exp_result = want;
    endtask

    task automatic run_measurement(input logic [W_N_MAX-1:0] cnts [N_SAMPLES], input bit noisy);
        int rst0 = rst_pulses;
        int rv0  = rv_pulses;
        do_start(1'b0);
        run_samples(cnts, 0, noisy);
        check("meas_rst_pulses", rst_pulses - rst0, N_SAMPLES);
        check("meas_rv_pulses", rv_pulses - rv0, 1);
    endtask

    // Entered on the first WAIT cycle of a sample that never sees an edge.
    task automatic wait_timeout(input int idx);
        for (int j = 1; j < TIMEOUT; j++) begin
            cnt_count = 16'($urandom);
            step();
        end
        check("to_pre_err", timeout_err, 0);
        check("to_pre_busy", busy, 1);
        step();
        check("to_err", timeout_err, 1);
        check("to_busy", busy, 0);
        check("to_en", cnt_enable, 0);
        check("to_res", result, exp_result);
        check("to_idx", sample_idx, idx);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst"}, cnt_rst, 0);
        check({tag, "_en"}, cnt_enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_idx"}, sample_idx, 0);
        check({tag, "_res"}, result, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_err"}, timeout_err, 0);
    endtask

    initial begin
        logic [W_N_MAX-1:0] cnts [N_SAMPLES];
        int rv0;
        int j;

        reset = 1'b1; start = 1'b0; abort = 1'b0; cnt_valid = 1'b0; cnt_count = '0;
        step(); step();
        reset = 1'b0;
        check_reset_outputs("init");

        // Nominal average: (10+11+12+13)>>2 = 11.
        cnts = '{16'd10, 16'd11, 16'd12, 16'd13};
        run_measurement(cnts, 1'b0);
        check("nom_result", result, 11);

        // Timeout with previous result retained, then start clears the flag.
        rv0 = rv_pulses;
        do_start(1'b0);
        cnt_valid = 1'b0;
        step();
        wait_timeout(0);
        check("to_rv_none", rv_pulses - rv0, 0);
        for (int i = 0; i < N_SAMPLES; i++) cnts[i] = rand_cnt();
        do_start(1'b0);
        run_samples(cnts, 0, 1'b0);

        // Full-scale counts do not wrap.
        cnts = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_measurement(cnts, 1'b0);
        check("max_result", result, 16'hFFFF);

        // Valid held high across re-arm: one capture, then timeout.
        do_start(1'b0);
        cnt_valid = 1'b0;
        step();
        cnt_valid = 1'b1;
        cnt_count = 16'h1234;
        step();
        step();
        check("hold_arm_idx", sample_idx, 1);
        check("hold_arm_rst", cnt_rst, 1);
        step();
        wait_timeout(1);
        cnt_valid = 1'b0;
        // Reset in IDLE clears the sticky error and the held result.
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_result = '0;
        check_reset_outputs("idle_rst");

        // Abort after two samples.
        for (int i = 0; i < N_SAMPLES; i++) cnts[i] = rand_cnt();
        run_measurement(cnts, 1'b0);
        rv0 = rv_pulses;
        do_start(1'b0);
        run_sample(rand_cnt(), 1, 1, 1'b0, 0, 1'b0, '0);
        run_sample(rand_cnt(), 2, 1, 1'b0, 1, 1'b0, '0);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_en", cnt_enable, 0);
        check("ab_idx", sample_idx, 2);
        check("ab_err", timeout_err, 0);
        step();
        check("ab_rv_none", rv_pulses - rv0, 0);
        check("ab_res", result, exp_result);

        // Abort coincident with a valid edge: no capture.
        do_start(1'b0);
        run_sample(rand_cnt(), 0, 1, 1'b0, 0, 1'b0, '0);
        step();
        cnt_valid = 1'b1;
        abort     = 1'b1;
        step();
        abort     = 1'b0;
        cnt_valid = 1'b0;
        check("abe_busy", busy, 0);
        check("abe_idx", sample_idx, 1);
        step(); step();
        check("abe_rv_none", rv_pulses - rv0, 0);
        check("abe_res", result, exp_result);

        // Start together with abort in IDLE: start wins.
        for (int i = 0; i < N_SAMPLES; i++) cnts[i] = rand_cnt();
        do_start(1'b1);
        run_samples(cnts, 0, 1'b0);

        // Start pulses while busy are ignored.
        for (int i = 0; i < N_SAMPLES; i++) cnts[i] = rand_cnt();
        run_measurement(cnts, 1'b1);

        // Reset during CAPTURE zeroes everything including result.
        cnts = '{16'd1000, 16'd2000, 16'd3000, 16'd4000};
        run_measurement(cnts, 1'b0);
        check("pre_rst_res", result, 2500);
        do_start(1'b0);
        cnt_valid = 1'b0;
        step();
        cnt_valid = 1'b1;
        step();
        check("rstcap_en", cnt_enable, 0);
        cnt_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_result = '0;
        check_reset_outputs("cap_rst");

        // Edge on the watchdog's last cycle wins over expiry.
        for (int i = 0; i < N_SAMPLES; i++) cnts[i] = rand_cnt();
        do_start(1'b0);
        cnt_valid = 1'b0;
        step();
        for (int i = 1; i < TIMEOUT; i++) step();
        cnt_valid = 1'b1;
        cnt_count = cnts[0];
        step();
        check("ee_err", timeout_err, 0);
        check("ee_busy", busy, 1);
        check("ee_en", cnt_enable, 0);
        cnt_valid = 1'b0;
        step();
        check("ee_idx", sample_idx, 1);
        check("ee_rst", cnt_rst, 1);
        run_samples(cnts, 1, 1'b0);

        // Randomized mix of complete, aborted and timed-out measurements.
        for (int it = 0; it < 40; it++) begin
            int kind = $urandom_range(0, 3);
            for (int i = 0; i < N_SAMPLES; i++) cnts[i] = rand_cnt();
            if (kind <= 1) begin
                run_measurement(cnts, 1'($urandom_range(0, 1)));
            end else begin
                rv0 = rv_pulses;
                j   = $urandom_range(0, N_SAMPLES - 1);
                do_start(1'b0);
                for (int i = 0; i < j; i++)
                    run_sample(cnts[i], $urandom_range(0, 3), 1, 1'b0, i, 1'b1, '0);
                cnt_valid = 1'b0;
                step();
                if (kind == 2) begin
                    repeat ($urandom_range(0, 4)) step();
                    cnt_valid = 1'($urandom_range(0, 1));
                    abort     = 1'b1;
                    step();
                    abort     = 1'b0;
                    cnt_valid = 1'b0;
                    check("rab_busy", busy, 0);
                    check("rab_idx", sample_idx, j);
                    check("rab_en", cnt_enable, 0);
                end else begin
                    wait_timeout(j);
                end
                step();
                check("rnd_rv_none", rv_pulses - rv0, 0);
                check("rnd_res", result, exp_result);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
